// File: rtl/sch_sweep_checker_pkg.sv
// Shared sizing and FSM encoding for the Sch sweep checker.
package sch_pkg;

    localparam int N_DEF     = 4;
    localparam int VEC_W_DEF = 5 * N_DEF + 1;
    localparam int RES_W_DEF = 4 * N_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sch_state_e;

endpackage

// File: rtl/sch_sweep_checker_err_capture.sv
// Compares the two implementation results, keeps a saturating mismatch count
// and latches the stimulus vector of the first mismatch of a sweep.
module sch_err_capture
    import sch_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF,
    parameter int RES_W = RES_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             cmp_en,
    input  logic [VEC_W-1:0] vec,
    input  logic [RES_W-1:0] res1,
    input  logic [RES_W-1:0] res2,
    output logic [VEC_W:0]   err_cnt,
    output logic             first_err_valid,
    output logic [VEC_W-1:0] first_err_vec
);

    logic [VEC_W:0]   err_cnt_q, err_cnt_d;
    logic             first_err_valid_q, first_err_valid_d;
    logic [VEC_W-1:0] first_err_vec_q, first_err_vec_d;
    logic             mismatch;

    assign mismatch = cmp_en && (res1 != res2);

    always_comb begin
        err_cnt_d         = err_cnt_q;
        first_err_valid_d = first_err_valid_q;
        first_err_vec_d   = first_err_vec_q;
        if (clear) begin
            err_cnt_d         = '0;
            first_err_valid_d = 1'b0;
            first_err_vec_d   = '0;
        end else if (mismatch) begin
            if (!(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + {{VEC_W{1'b0}}, 1'b1};
            end
            if (!first_err_valid_q) begin
                first_err_valid_d = 1'b1;
                first_err_vec_d   = vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_vec_q   <= '0;
        end else begin
            err_cnt_q         <= err_cnt_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_vec_q   <= first_err_vec_d;
        end
    end

    assign err_cnt         = err_cnt_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_vec   = first_err_vec_q;

endmodule

// File: rtl/sch_sweep_checker.sv
// Exhaustive stimulus sweep that drives two Sch implementations with every
// operand/carry combination and records where their results disagree.
module sch_sweep_checker
    import sch_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int VEC_W = 5 * N + 1,
    localparam int RES_W = 4 * N + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic [N-1:0]     a1,
    output logic [N-1:0]     a0,
    output logic [N-1:0]     m2,
    output logic [N-1:0]     m1,
    output logic [N-1:0]     m0,
    output logic             cin,
    input  logic [RES_W-1:0] res1,
    input  logic [RES_W-1:0] res2,
    output logic             busy,
    output logic             done,
    output logic [VEC_W:0]   err_cnt,
    output logic             first_err_valid,
    output logic [VEC_W-1:0] first_err_vec
);

    sch_state_e       state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             clear;
    logic             cmp_en;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        clear   = 1'b0;
        cmp_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                vec_d = '0;
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (!hold) begin
                    cmp_en = 1'b1;
                    // Last vector: stop without wrapping so the final stimulus stays visible.
                    if (&vec_q) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + {{(VEC_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    clear   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    sch_err_capture #(
        .VEC_W (VEC_W),
        .RES_W (RES_W)
    ) u_err_capture (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .cmp_en          (cmp_en),
        .vec             (vec_q),
        .res1            (res1),
        .res2            (res2),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec)
    );

    assign cin  = vec_q[5*N];
    assign a1   = vec_q[5*N-1:4*N];
    assign a0   = vec_q[4*N-1:3*N];
    assign m2   = vec_q[3*N-1:2*N];
    assign m1   = vec_q[2*N-1:N];
    assign m0   = vec_q[N-1:0];
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_sch_sweep_checker.sv
// Directed bench for the sweep checker at N=1 (64-vector sweep).
module tb_sch_sweep_checker;

    localparam int N     = 1;
    localparam int VEC_W = 5 * N + 1;
    localparam int RES_W = 4 * N + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             hold = 1'b0;
    logic [N-1:0]     a1, a0, m2, m1, m0;
    logic             cin;
    logic [RES_W-1:0] res1, res2;
    logic             busy, done;
    logic [VEC_W:0]   err_cnt;
    logic             first_err_valid;
    logic [VEC_W-1:0] first_err_vec;
    logic [VEC_W-1:0] vec_obs;

    int total = 0;
    int bad   = 0;
    int mode  = 0;  // 0: equal, 1: mismatch only at 6'h2A, 2: always mismatch

    always #5 clk = ~clk;

    sch_sweep_checker #(.N(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .hold            (hold),
        .a1              (a1),
        .a0              (a0),
        .m2              (m2),
        .m1              (m1),
        .m0              (m0),
        .cin             (cin),
        .res1            (res1),
        .res2            (res2),
        .busy            (busy),
        .done            (done),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec)
    );

    // Stand-in implementations: res1 is a fixed function of the stimulus,
    // res2 deviates from it according to the current mode.
    assign vec_obs = {cin, a1, a0, m2, m1, m0};
    assign res1    = vec_obs[RES_W-1:0] ^ {RES_W{vec_obs[VEC_W-1]}};
    always_comb begin
        res2 = res1;
        if (mode == 2) res2 = ~res1;
        else if (mode == 1 && vec_obs == 6'h2A) res2 = res1 ^ 5'h01;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_to_done(output int cyc, output bit timed_out);
        cyc = 0;
        while (!done && cyc < 300) begin
            if (busy) cyc++;
            @(negedge clk);
        end
        timed_out = !done;
    endtask

    task automatic wait_vec(input logic [VEC_W-1:0] target, output int cyc, output bit timed_out);
        cyc = 0;
        while (vec_obs != target && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        timed_out = (vec_obs != target);
    endtask

    task automatic test_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        total++;
        if ({busy, done, first_err_valid} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, first_err_valid});
        end
        total++;
        if (err_cnt !== 7'd0 || first_err_vec !== 6'd0 || vec_obs !== 6'd0) begin
            bad++; $display("FAIL reset_data got cnt=%0d fv=%h vec=%h exp 0/0/0", err_cnt, first_err_vec, vec_obs);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || vec_obs !== 6'd0) begin
            bad++; $display("FAIL idle_no_start got busy=%b vec=%h exp 0/0", busy, vec_obs);
        end
    endtask

    task automatic test_sweep_equal();
        int cyc; bit to;
        mode = 0;
        pulse_start();
        total++;
        if (busy !== 1'b1 || vec_obs !== 6'd0) begin
            bad++; $display("FAIL run_entry got busy=%b vec=%h exp 1/00", busy, vec_obs);
        end
        run_to_done(cyc, to);
        total++;
        if (to || cyc != 64) begin
            bad++; $display("FAIL equal_latency got cyc=%0d timeout=%0b exp 64/0", cyc, to);
        end
        total++;
        if (err_cnt !== 7'd0 || first_err_valid !== 1'b0) begin
            bad++; $display("FAIL equal_result got cnt=%0d v=%b exp 0/0", err_cnt, first_err_valid);
        end
        total++;
        if (vec_obs !== 6'h3F || cin !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL done_vec got vec=%h busy=%b exp 3F/0", vec_obs, busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b1 || vec_obs !== 6'h3F) begin
            bad++; $display("FAIL done_hold got done=%b vec=%h exp 1/3F", done, vec_obs);
        end
    endtask

    task automatic test_single_err();
        int cyc; bit to;
        mode = 1;
        pulse_start();
        run_to_done(cyc, to);
        total++;
        if (to || err_cnt !== 7'd1 || first_err_valid !== 1'b1 || first_err_vec !== 6'h2A) begin
            bad++; $display("FAIL single_err got cnt=%0d v=%b fv=%h to=%0b exp 1/1/2A/0",
                            err_cnt, first_err_valid, first_err_vec, to);
        end
    endtask

    task automatic test_all_err();
        int cyc; bit to;
        mode = 2;
        pulse_start();
        total++;
        if (err_cnt !== 7'd0 || first_err_valid !== 1'b0) begin
            bad++; $display("FAIL restart_clear got cnt=%0d v=%b exp 0/0", err_cnt, first_err_valid);
        end
        run_to_done(cyc, to);
        total++;
        if (to || err_cnt !== 7'd64 || first_err_vec !== 6'h00 || first_err_valid !== 1'b1) begin
            bad++; $display("FAIL all_err got cnt=%0d fv=%h v=%b exp 64/00/1", err_cnt, first_err_vec, first_err_valid);
        end
        // Hold in DONE without start must keep results.
        @(negedge clk) hold = 1'b1;
        @(negedge clk) hold = 1'b0;
        total++;
        if (done !== 1'b1 || err_cnt !== 7'd64) begin
            bad++; $display("FAIL done_hold_results got done=%b cnt=%0d exp 1/64", done, err_cnt);
        end
    endtask

    task automatic test_hold();
        int cyc, c2; bit to;
        mode = 2;
        // start and hold together in DONE: restart wins.
        @(negedge clk) begin start = 1'b1; hold = 1'b1; end
        @(negedge clk) begin start = 1'b0; hold = 1'b0; end
        total++;
        if (busy !== 1'b1 || vec_obs !== 6'd0 || err_cnt !== 7'd0) begin
            bad++; $display("FAIL start_hold_done got busy=%b vec=%h cnt=%0d exp 1/00/0", busy, vec_obs, err_cnt);
        end
        wait_vec(6'd10, cyc, to);
        hold = 1'b1;
        repeat (5) begin cyc++; @(negedge clk); end
        total++;
        if (to || vec_obs !== 6'd10 || err_cnt !== 7'd10) begin
            bad++; $display("FAIL hold_freeze got vec=%0d cnt=%0d exp 10/10", vec_obs, err_cnt);
        end
        hold = 1'b0;
        // start while running is ignored.
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc++;
        total++;
        if (vec_obs !== 6'd11 || busy !== 1'b1) begin
            bad++; $display("FAIL start_in_run got vec=%0d busy=%b exp 11/1", vec_obs, busy);
        end
        run_to_done(c2, to);
        total++;
        if (to || cyc + c2 != 69 || err_cnt !== 7'd64) begin
            bad++; $display("FAIL hold_latency got cyc=%0d cnt=%0d exp 69/64", cyc + c2, err_cnt);
        end
    endtask

    task automatic test_rst_mid();
        int cyc; bit to;
        mode = 2;
        pulse_start();
        wait_vec(6'd20, cyc, to);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (to || busy !== 1'b0 || done !== 1'b0 || vec_obs !== 6'd0 || err_cnt !== 7'd0 ||
            first_err_valid !== 1'b0 || first_err_vec !== 6'd0) begin
            bad++; $display("FAIL rst_mid got busy=%b done=%b vec=%h cnt=%0d v=%b exp all 0",
                            busy, done, vec_obs, err_cnt, first_err_valid);
        end
        start = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_priority got busy=%b exp 0", busy);
        end
        rst = 1'b0;
        start = 1'b0;
        pulse_start();
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || vec_obs !== 6'd1 || err_cnt !== 7'd1) begin
            bad++; $display("FAIL rst_restart got busy=%b vec=%h cnt=%0d exp 1/01/1", busy, vec_obs, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sweep_equal();
        test_single_err();
        test_all_err();
        test_hold();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
